// File: rtl/rv_config.sv
// Shared core configuration: text segment geometry and reset vector.
package rv_config;
    localparam int          TEXT_BITS    = 24;
    localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
endpackage

// File: rtl/rv_fetch_types.sv
// Types shared by the fetch front-end: queued {pc, inst} entry and PC alignment mask.
package rv_fetch_types;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/example_fetch_queue_if.sv
// Fetch-side bus: text memory port, redirect request and instruction handshake to the core.
interface example_fetch_queue_if;
    logic [rv_config::TEXT_BITS-3:0] text_address;
    logic [31:0]                     text_q;
    logic                            redirect_valid;
    logic [31:0]                     redirect_pc;
    logic                            inst_valid;
    logic                            inst_ready;
    logic [31:0]                     inst;
    logic [31:0]                     inst_pc;

    modport master (
        output text_address,
        input  text_q,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc
    );

    modport slave (
        input  text_address,
        output text_q,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc
    );
endinterface

// File: rtl/example_fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries; flush clears pointers and count and wins over push/pop.
module example_fetch_fifo
    import rv_fetch_types::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO may still accept a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/example_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, queues {pc, inst} and serves the core.
// Optional FETCH_BYPASS_EN: zero-latency pass-through of text_q/pc while the queue is empty.
module example_fetch_queue
    import rv_config::*;
    import rv_fetch_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic                  clock,
    input  logic                  reset,
    example_fetch_queue_if.master bus
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    logic [31:0]   pc;
    logic          pop;
    logic          push;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

    assign pop    = bus.inst_valid & bus.inst_ready;
    assign push   = ~bus.redirect_valid & ((fifo_count < FULL_COUNT) | pop);
    assign wentry = '{pc: pc, inst: bus.text_q};
    assign bus.text_address = pc[TEXT_BITS-1:2];

`ifdef FETCH_BYPASS_EN
    logic bypass;

    // An empty queue exposes the word being fetched right now; a taken word never enters the FIFO.
    assign bypass    = fifo_empty & ~bus.redirect_valid & ~reset;
    assign fifo_pop  = pop & ~bypass;
    assign fifo_push = push & ~(bypass & bus.inst_ready);

    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (bypass) begin
            bus.inst_valid = 1'b1;
            bus.inst       = bus.text_q;
            bus.inst_pc    = pc;
        end else if (!fifo_empty) begin
            bus.inst_valid = 1'b1;
            bus.inst       = head.inst;
            bus.inst_pc    = head.pc;
        end
    end
`else
    assign fifo_pop  = pop;
    assign fifo_push = push;

    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (!fifo_empty) begin
            bus.inst_valid = 1'b1;
            bus.inst       = head.inst;
            bus.inst_pc    = head.pc;
        end
    end
`endif

    // Redirect outranks fetch advance; push also covers a word consumed straight from the bypass.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc & FETCH_ALIGN_MASK;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    example_fetch_fifo #(
        .DEPTH (DEPTH)
    ) fifo_inst (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (bus.redirect_valid),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_example_fetch_queue.sv
// Scoreboard bench for example_fetch_queue: stimulus queues expected {pc, inst}, a monitor checks handshakes.
module tb_example_fetch_queue;

    logic clock;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;
    logic [63:0] sbq[$];

    example_fetch_queue_if fq();

    example_fetch_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (fq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: word n of the text segment (counted from 0x00400000) holds 0x10000000 + n.
    assign fq.text_q = 32'h1000_0000 + (32'(fq.text_address) - 32'h0010_0000);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic ready, input logic redirValid, input logic [31:0] redirPc);
        fq.inst_ready     = ready;
        fq.redirect_valid = redirValid;
        fq.redirect_pc    = redirPc;
    endtask

    task automatic pushExpected(input logic [31:0] startPc, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = startPc + 32'(4 * i);
            sbq.push_back({p, 32'h1000_0000 + ((p - 32'h0040_0000) >> 2)});
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < maxCycles) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkCount++;
        if (sbq.size() == 0) passCount++;
        else begin
            $display("[TB] FAIL drain_timeout: %0d entries left, required 0", sbq.size());
            sbq.delete();
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset && fq.inst_valid && fq.inst_ready) begin
            if (sbq.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_pop: got pc %h, required no handshake", fq.inst_pc);
            end else begin
                logic [63:0] e;
                e = sbq.pop_front();
                checkOutput("sb_inst_pc", fq.inst_pc, e[63:32]);
                checkOutput("sb_inst", fq.inst, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("reset_inst_valid", 32'(fq.inst_valid), 32'h0);
        checkOutput("reset_inst", fq.inst, 32'h0);
        checkOutput("reset_inst_pc", fq.inst_pc, 32'h0);
        checkOutput("reset_text_address", 32'(fq.text_address), 32'h0010_0000);

        // Streaming with a consumer that is always ready.
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
`ifdef FETCH_BYPASS_EN
        checkOutput("bypass_inst_valid", 32'(fq.inst_valid), 32'h1);
        checkOutput("bypass_inst_pc", fq.inst_pc, 32'h0040_0000);
        checkOutput("bypass_inst", fq.inst, 32'h1000_0000);
`else
        checkOutput("first_latency_valid", 32'(fq.inst_valid), 32'h0);
`endif
        pushExpected(32'h0040_0000, 6);
        waitDrain(40);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Stall: fill the queue and hold.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            if (c >= 4) begin
                checkOutput("stall_text_address", 32'(fq.text_address), 32'h0010_0004);
                checkOutput("stall_inst_pc", fq.inst_pc, 32'h0040_0000);
            end
        end
        checkOutput("stall_inst", fq.inst, 32'h1000_0000);

        // Full queue with a ready consumer: push and pop every cycle.
        pushExpected(32'h0040_0000, 4);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("full_inst_valid", 32'(fq.inst_valid), 32'h1);
            checkOutput("full_text_address", 32'(fq.text_address), 32'h0010_0004 + 32'(k));
            @(posedge clock);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("full_sb_left", 32'(sbq.size()), 32'h0);

        // Asynchronous reset in the middle of a cycle with the queue full.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset_inst_valid", 32'(fq.inst_valid), 32'h0);
        checkOutput("midreset_inst_pc", fq.inst_pc, 32'h0);
        checkOutput("midreset_text_address", 32'(fq.text_address), 32'h0010_0000);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Redirect with three queued entries.
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkOutput("queued_inst_pc", fq.inst_pc, 32'h0040_0000);
        applyStimulus(1'b0, 1'b1, 32'h0040_0103);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redirect_text_address", 32'(fq.text_address), 32'h0010_0040);
`ifdef FETCH_BYPASS_EN
        checkOutput("redirect_bypass_pc", fq.inst_pc, 32'h0040_0100);
`else
        checkOutput("redirect_inst_valid", 32'(fq.inst_valid), 32'h0);
`endif
        @(posedge clock);
        #1;
        checkOutput("after_redirect_valid", 32'(fq.inst_valid), 32'h1);
        checkOutput("after_redirect_pc", fq.inst_pc, 32'h0040_0100);
        checkOutput("after_redirect_inst", fq.inst, 32'h1000_0040);
        pushExpected(32'h0040_0100, 4);
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDrain(40);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
